// File: rtl/tsc_pkg.sv
// Shared definitions for the 16-bit TSC CPU control path.
// Holds the opcode/funct constants, FSM state encoding, datapath select
// encodings, the control bundle and the instruction classifier.
// aluControl and the datapath use this package too.
package tsc_pkg;

  localparam int WORD_SIZE = 16;
  localparam int CNT_WIDTH = 16;

  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  localparam logic [5:0] FN_ALU_LAST = 6'd7;
  localparam logic [5:0] FN_JPR      = 6'd25;
  localparam logic [5:0] FN_JRL      = 6'd26;
  localparam logic [5:0] FN_WWD      = 6'd28;
  localparam logic [5:0] FN_HLT      = 6'd29;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_TARGET = 2'b10;
  localparam logic [1:0] PCS_RS     = 2'b11;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_SEXT = 2'b10;
  localparam logic [1:0] SRCB_ZEXT = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_R2 = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  typedef enum logic [2:0] {
    S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_BRANCH, C_ALU_R, C_ADI, C_ORI, C_LHI, C_LWD, C_SWD,
    C_JMP, C_JAL, C_JPR, C_JRL, C_WWD, C_HLT, C_NOP
  } inst_class_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_add_force;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       wwd;
    logic       is_halted;
  } ctrl_t;

  // Undefined opcodes and functs collapse to C_NOP so they retire from ID.
  function automatic inst_class_t inst_class(input logic [3:0] op, input logic [5:0] fn);
    inst_class_t c;
    c = C_NOP;
    case (op)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: c = C_BRANCH;
      OP_ADI:   c = C_ADI;
      OP_ORI:   c = C_ORI;
      OP_LHI:   c = C_LHI;
      OP_LWD:   c = C_LWD;
      OP_SWD:   c = C_SWD;
      OP_JMP:   c = C_JMP;
      OP_JAL:   c = C_JAL;
      OP_RTYPE: begin
        if (fn <= FN_ALU_LAST) begin
          c = C_ALU_R;
        end else begin
          case (fn)
            FN_JPR:  c = C_JPR;
            FN_JRL:  c = C_JRL;
            FN_WWD:  c = C_WWD;
            FN_HLT:  c = C_HLT;
            default: c = C_NOP;
          endcase
        end
      end
      default: c = C_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational control decode: state + opcode/funct (+ mem_ready in IF)
// -> datapath control bundle. No storage here.
module control_decode
  import tsc_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  inst_class_t cls;
  assign cls = inst_class(opcode, funct);

  // Per-state control decode; everything not named stays 0.
  always_comb begin
    ctrl = '0;
    case (state)
      S_IF: begin
        ctrl.mem_read      = 1'b1;
        ctrl.alu_src_b     = SRCB_ONE;
        ctrl.alu_add_force = 1'b1;
        // IR and PC+1 are committed only when the fetch actually completes.
        if (mem_ready) begin
          ctrl.ir_write  = 1'b1;
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCS_ALU;
        end
      end
      S_ID: begin
        // Speculatively compute the branch target into ALUOut.
        ctrl.alu_src_b     = SRCB_SEXT;
        ctrl.alu_add_force = 1'b1;
        case (cls)
          C_JMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCS_TARGET;
          end
          C_JAL: begin
            ctrl.pc_write   = 1'b1;
            ctrl.pc_source  = PCS_TARGET;
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = RD_R2;
            ctrl.mem_to_reg = M2R_PC;
          end
          C_JPR: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCS_RS;
          end
          C_JRL: begin
            ctrl.pc_write   = 1'b1;
            ctrl.pc_source  = PCS_RS;
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = RD_R2;
            ctrl.mem_to_reg = M2R_PC;
          end
          C_WWD:   ctrl.wwd = 1'b1;
          default: ;
        endcase
      end
      S_EX: begin
        case (cls)
          C_ALU_R: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_RT;
          end
          // Immediate ALU ops take rs on port A; LHI ignores it.
          C_ADI, C_LHI: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_SEXT;
          end
          C_ORI: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_ZEXT;
          end
          C_LWD, C_SWD: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_SEXT;
          end
          C_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_RT;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCS_ALUOUT;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_read  = (cls == C_LWD);
        ctrl.mem_write = (cls == C_SWD);
      end
      S_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = (cls == C_ALU_R) ? RD_RD : RD_RT;
        ctrl.mem_to_reg = (cls == C_LWD) ? M2R_MDR : M2R_ALUOUT;
      end
      S_HALT:  ctrl.is_halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM of the TSC CPU (IF/ID/EX/MEM/WB/HALT).
// Holds the state register, the latched opcode/funct and, when the
// CONTROL_INST_COUNT_EN macro is defined, the retired-instruction counter.
// All outputs are forced to 0 while reset is high.
module multicycle_control
  import tsc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic [5:0] funct,
  input  logic       bcond,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       alu_add_force,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       wwd,
  output logic       is_halted
`ifdef CONTROL_INST_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] num_inst
`endif
);

  state_t      state_reg, state_next;
  logic [3:0]  opcode_reg;
  logic [5:0]  funct_reg;
  logic [3:0]  opcode_eff;
  logic [5:0]  funct_eff;
  inst_class_t cls;
  ctrl_t       ctrl, ctrl_out;

  // The branch decision is applied in the datapath through pc_write_cond.
  logic unused_bcond;
  assign unused_bcond = bcond;

  // ID decodes the live IR fields; later states use the copy taken in ID.
  assign opcode_eff = (state_reg == S_ID) ? opcode : opcode_reg;
  assign funct_eff  = (state_reg == S_ID) ? funct  : funct_reg;
  assign cls        = inst_class(opcode_eff, funct_eff);

  // State register and opcode/funct latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IF;
      opcode_reg <= '0;
      funct_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_ID) begin
        opcode_reg <= opcode;
        funct_reg  <= funct;
      end
    end
  end

  // Next-state sequencing; memory states wait on mem_ready.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IF: if (mem_ready) state_next = S_ID;
      S_ID: begin
        case (cls)
          C_JMP, C_JAL, C_JPR, C_JRL, C_WWD, C_NOP: state_next = S_IF;
          C_HLT:   state_next = S_HALT;
          default: state_next = S_EX;
        endcase
      end
      S_EX: begin
        case (cls)
          C_LWD, C_SWD:                 state_next = S_MEM;
          C_ALU_R, C_ADI, C_ORI, C_LHI: state_next = S_WB;
          default:                      state_next = S_IF;
        endcase
      end
      S_MEM:   if (mem_ready) state_next = (cls == C_LWD) ? S_WB : S_IF;
      S_WB:    state_next = S_IF;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IF;
    endcase
  end

  control_decode u_decode (
    .state     (state_reg),
    .opcode    (opcode_eff),
    .funct     (funct_eff),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign ctrl_out      = reset ? '0 : ctrl;
  assign mem_read      = ctrl_out.mem_read;
  assign mem_write     = ctrl_out.mem_write;
  assign i_or_d        = ctrl_out.i_or_d;
  assign ir_write      = ctrl_out.ir_write;
  assign pc_write      = ctrl_out.pc_write;
  assign pc_write_cond = ctrl_out.pc_write_cond;
  assign pc_source     = ctrl_out.pc_source;
  assign alu_src_a     = ctrl_out.alu_src_a;
  assign alu_src_b     = ctrl_out.alu_src_b;
  assign alu_add_force = ctrl_out.alu_add_force;
  assign reg_write     = ctrl_out.reg_write;
  assign reg_dst       = ctrl_out.reg_dst;
  assign mem_to_reg    = ctrl_out.mem_to_reg;
  assign wwd           = ctrl_out.wwd;
  assign is_halted     = ctrl_out.is_halted;

`ifdef CONTROL_INST_COUNT_EN
  logic                 inst_done;
  logic [CNT_WIDTH-1:0] num_inst_reg;

  // An instruction retires on its last cycle before IF, or on entering HALT.
  assign inst_done = (state_reg != S_IF) && (state_reg != S_HALT) &&
                     ((state_next == S_IF) || (state_next == S_HALT));

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      num_inst_reg <= '0;
    end else if (inst_done) begin
      num_inst_reg <= num_inst_reg + 1'b1;
    end
  end

  assign num_inst = num_inst_reg;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: each instruction is expanded from the
// per-phase control rules into a list of expected per-cycle output vectors
// and replayed with randomized memory wait states and don't-care inputs.
module tb_multicycle_control;

  logic       clk, reset, bcond, mem_ready;
  logic [3:0] opcode;
  logic [5:0] funct;
  logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
  logic       alu_src_a, alu_add_force, reg_write, wwd, is_halted;
  logic [1:0] pc_source, alu_src_b, reg_dst, mem_to_reg;
`ifdef CONTROL_INST_COUNT_EN
  logic [15:0] num_inst;
`endif

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_add_force;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       wwd;
    logic       is_halted;
  } ctl_t;

  typedef struct {
    ctl_t v;
    ctl_t m;
    logic mr;
    bit   in_if;
  } step_t;

  localparam int K_BR = 0, K_R = 1, K_ADI = 2, K_ORI = 3, K_LHI = 4, K_LWD = 5, K_SWD = 6;
  localparam int K_JMP = 7, K_JAL = 8, K_JPR = 9, K_JRL = 10, K_WWD = 11, K_HLT = 12, K_NOP = 13;

  int    n_checks = 0;
  int    n_errors = 0;
  int    exp_cnt = 0;
  int    n_instr = 0;
  int    bcond_mode = -1;
  step_t expq[$];
  ctl_t  obs;

  assign obs = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
                alu_src_a, alu_src_b, alu_add_force, reg_write, reg_dst, mem_to_reg,
                wwd, is_halted};

  multicycle_control dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .funct         (funct),
    .bcond         (bcond),
    .mem_ready     (mem_ready),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .i_or_d        (i_or_d),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_add_force (alu_add_force),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .wwd           (wwd),
    .is_halted     (is_halted)
`ifdef CONTROL_INST_COUNT_EN
    ,
    .num_inst      (num_inst)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int kind(input logic [3:0] op, input logic [5:0] fn);
    if (op <= 4'd3) return K_BR;
    case (op)
      4'd4:  return K_ADI;
      4'd5:  return K_ORI;
      4'd6:  return K_LHI;
      4'd7:  return K_LWD;
      4'd8:  return K_SWD;
      4'd9:  return K_JMP;
      4'd10: return K_JAL;
      4'd15: begin
        if (fn <= 6'd7) return K_R;
        if (fn == 6'd25) return K_JPR;
        if (fn == 6'd26) return K_JRL;
        if (fn == 6'd28) return K_WWD;
        if (fn == 6'd29) return K_HLT;
        return K_NOP;
      end
      default: return K_NOP;
    endcase
  endfunction

  task automatic push(input ctl_t v, input ctl_t m, input logic mr, input bit in_if);
    step_t s;
    s.v = v; s.m = m; s.mr = mr; s.in_if = in_if;
    expq.push_back(s);
  endtask

  // Expected per-cycle outputs for one instruction, straight from the phase rules.
  task automatic build(input logic [3:0] op, input logic [5:0] fn, input int if_wait, input int mem_wait);
    ctl_t e, full, no_a;
    int   k;
    k = kind(op, fn);
    full = '1;
    no_a = '1;
    no_a.alu_src_a = 1'b0;
    expq.delete();
    // fetch
    e = '0; e.mem_read = 1; e.alu_src_b = 2'b01; e.alu_add_force = 1;
    for (int i = 0; i < if_wait; i++) push(e, full, 1'b0, 1'b1);
    e.ir_write = 1; e.pc_write = 1; e.pc_source = 2'b00;
    push(e, full, 1'b1, 1'b1);
    // decode
    e = '0; e.alu_src_b = 2'b10; e.alu_add_force = 1;
    case (k)
      K_JMP: begin e.pc_write = 1; e.pc_source = 2'b10; end
      K_JAL: begin e.pc_write = 1; e.pc_source = 2'b10; e.reg_write = 1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; end
      K_JPR: begin e.pc_write = 1; e.pc_source = 2'b11; end
      K_JRL: begin e.pc_write = 1; e.pc_source = 2'b11; e.reg_write = 1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; end
      K_WWD: e.wwd = 1;
      default: ;
    endcase
    push(e, full, 1'($urandom), 1'b0);
    if (k >= K_JMP) return;
    // execute
    e = '0;
    case (k)
      K_BR: begin e.alu_src_a = 1; e.pc_write_cond = 1; e.pc_source = 2'b01; end
      K_R:  e.alu_src_a = 1;
      K_ADI, K_LHI: e.alu_src_b = 2'b10;
      K_ORI: e.alu_src_b = 2'b11;
      default: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
    endcase
    push(e, (k == K_ADI || k == K_ORI || k == K_LHI) ? no_a : full, 1'($urandom), 1'b0);
    if (k == K_BR) return;
    // memory
    if (k == K_LWD || k == K_SWD) begin
      e = '0; e.i_or_d = 1;
      if (k == K_LWD) e.mem_read = 1; else e.mem_write = 1;
      for (int i = 0; i < mem_wait; i++) push(e, full, 1'b0, 1'b0);
      push(e, full, 1'b1, 1'b0);
      if (k == K_SWD) return;
    end
    // write-back
    e = '0; e.reg_write = 1;
    if (k == K_R) e.reg_dst = 2'b01;
    if (k == K_LWD) e.mem_to_reg = 2'b01;
    push(e, full, 1'($urandom), 1'b0);
  endtask

  // Replay expq (optionally only its first stop_after cycles); starts just after a posedge.
  task automatic run_steps(input logic [3:0] op, input logic [5:0] fn, input string tag, input int stop_after);
    for (int i = 0; i < expq.size(); i++) begin
      if (stop_after >= 0 && i >= stop_after) break;
      mem_ready = expq[i].mr;
      bcond = (bcond_mode < 0) ? 1'($urandom) : 1'(bcond_mode);
      if (expq[i].in_if) begin
        opcode = 4'($urandom); funct = 6'($urandom);
      end else begin
        opcode = op; funct = fn;
      end
      @(negedge clk);
      check($sformatf("%s cyc%0d", tag, i), 32'(obs & expq[i].m), 32'(expq[i].v & expq[i].m));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_instr(input logic [3:0] op, input logic [5:0] fn, input int if_wait,
                          input int mem_wait, input string tag);
    int cycles;
    build(op, fn, if_wait, mem_wait);
    cycles = expq.size();
`ifdef CONTROL_INST_COUNT_EN
    check({tag, " num_inst"}, 32'(num_inst), 32'(exp_cnt[15:0]));
`endif
    run_steps(op, fn, tag, -1);
    exp_cnt++;
    n_instr++;
    $display("instr %0d %s op=%0d fn=%0d if_wait=%0d mem_wait=%0d cycles=%0d",
             n_instr, tag, op, fn, if_wait, mem_wait, cycles);
  endtask

  task automatic apply_reset(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      reset = 1'b1; mem_ready = 1'b1; bcond = 1'($urandom);
      opcode = 4'($urandom); funct = 6'($urandom);
      @(negedge clk);
      check($sformatf("%s cyc%0d", tag, i), 32'(obs), 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    exp_cnt = 0;
    $display("reset %s cycles=%0d", tag, n);
  endtask

  logic [5:0] fn_tab [12];
  logic [3:0] rop;
  logic [5:0] rfn;
  ctl_t       he;

  initial begin
    fn_tab = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd25, 6'd26, 6'd28, 6'd63};
    reset = 1'b1; mem_ready = 1'b0; bcond = 1'b0; opcode = '0; funct = '0;
    apply_reset(2, "power-on");

    // reset in the middle of an LWD memory wait
    build(4'd7, 6'd0, 0, 3);
    run_steps(4'd7, 6'd0, "LWD-abort", 4);
    apply_reset(2, "mid-LWD");

    do_instr(4'd4, 6'd0, 1, 0, "ADI");
    do_instr(4'd7, 6'd0, 3, 2, "LWD-wait");
    bcond_mode = 1;
    do_instr(4'd1, 6'd0, 0, 0, "BEQ");
    bcond_mode = 0;
    do_instr(4'd0, 6'd0, 0, 0, "BNE");
    bcond_mode = -1;
    do_instr(4'd10, 6'd0, 0, 0, "JAL");
    do_instr(4'd15, 6'd26, 0, 0, "JRL");
    do_instr(4'd8, 6'd0, 2, 1, "SWD");
    do_instr(4'd15, 6'd3, 0, 0, "R-ORR");
    do_instr(4'd12, 6'd0, 0, 0, "NOP-op");

    for (int n = 0; n < 150; n++) begin
      rop = 4'($urandom_range(0, 15));
      rfn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 11)];
      if (rop == 4'd15 && rfn == 6'd29) rfn = 6'd28;
      do_instr(rop, rfn, $urandom_range(0, 2), $urandom_range(0, 2), "rand");
    end

    // halt is absorbing regardless of inputs
    do_instr(4'd15, 6'd29, 1, 0, "HLT");
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom); bcond = 1'($urandom);
      opcode = 4'($urandom); funct = 6'($urandom);
      @(negedge clk);
      he = '0;
      he.is_halted = 1'b1;
      check($sformatf("HALT cyc%0d", i), 32'(obs), 32'(he));
`ifdef CONTROL_INST_COUNT_EN
      check($sformatf("HALT num_inst cyc%0d", i), 32'(num_inst), 32'(exp_cnt[15:0]));
`endif
      @(posedge clk);
      #1;
    end
    apply_reset(1, "after-HALT");
    do_instr(4'd15, 6'd28, 0, 0, "WWD");
    do_instr(4'd9, 6'd0, 1, 0, "JMP");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
